// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern driver: FSM states, the
// 29-bit LFSR taps, the MISR polynomial and the default seed.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // x^29 + x^27 + 1, Fibonacci form
  localparam int LFSR_W      = 29;
  localparam int LFSR_TAP_HI = 28;
  localparam int LFSR_TAP_LO = 26;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] MISR_POLY = 16'h1021;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 29'h1;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shifts with polynomial feedback and folds
// the zero-extended response bus in every enabled cycle.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               OUT_W = 7,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [OUT_W-1:0] resp,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  logic             fb;
  logic [SIG_W-1:0] resp_ext;

  // POLY bit k taps register bit k-1; the top bit is always a tap
  always_comb begin
    resp_ext             = '0;
    resp_ext[OUT_W-1:0]  = resp;
    fb                   = sig[SIG_W-1] ^ (^(sig[SIG_W-2:0] & POLY[SIG_W-1:1]));
    if (clear) begin
      sig_next = '0;
    end else if (en) begin
      sig_next = {sig[SIG_W-2:0], fb} ^ resp_ext;
    end else begin
      sig_next = sig;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/bist_pattern_driver.sv
// BIST driver: LFSR stimulus for a combinational netlist, MISR compaction of its
// response, golden compare. Optional BIST_ABORT_EN adds an abort input.
module bist_pattern_driver
  import bist_pkg::*;
#(
  parameter int              IN_W      = LFSR_W,
  parameter int              OUT_W     = 7,
  parameter int              PAT_CNT   = 1024,
  parameter logic [IN_W-1:0] LFSR_SEED = DEFAULT_SEED,
  parameter int              SIG_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [IN_W-1:0]  pat_o,
  input  logic [OUT_W-1:0] resp_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
`ifdef BIST_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int CNT_W = (PAT_CNT > 0) ? $clog2(PAT_CNT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((PAT_CNT > 0) ? PAT_CNT - 1 : 0);
  // An all-zero LFSR would lock up, so a zero seed is replaced by all-ones
  localparam logic [IN_W-1:0] SEED_VAL = (LFSR_SEED == '0) ? '1 : LFSR_SEED;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  lfsr_next;
  logic [SIG_W-1:0] sig_next;
  logic             abort_req;
  logic             misr_clear;
  logic             misr_en;

`ifdef BIST_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign lfsr_next  = {pat_o[IN_W-2:0], pat_o[LFSR_TAP_HI] ^ pat_o[LFSR_TAP_LO]};
  // An abort leaves the signature untouched for debug
  assign misr_clear = (state == SEED) && !abort_req;
  assign misr_en    = (state == RUN) && !abort_req;

  bist_misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (misr_clear),
    .en       (misr_en),
    .resp     (resp_i),
    .sig      (signature),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pat_o <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SEED;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        SEED: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            pat_o <= SEED_VAL;
            cnt   <= '0;
            if (PAT_CNT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == golden_sig);
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            pat_o <= lfsr_next;
            cnt   <= cnt + CNT_W'(1);
            // sig_next already includes this cycle's (final) response
            if (cnt == LAST_CNT) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == golden_sig);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_pattern_driver.sv
// Randomized self-checking bench: five driver instances with different pattern
// counts and seeds, checked against a behavioural LFSR/MISR model.
module tb_bist_pattern_driver;

  localparam int NI = 5;
  // 0: 16 patterns, 1: zero patterns/zero seed, 2: single pattern on 7'h55,
  // 3: full 1024-pattern loopback, 4: LFSR wrap from the top bit
  localparam int          PCNT  [NI] = '{16, 0, 1, 1024, 2};
  localparam logic [28:0] SEEDS [NI] = '{29'h1, 29'h0, 29'h1, 29'h0123_4567, 29'h1000_0000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [NI];
  logic        abort [NI];
  logic [15:0] gold  [NI];
  logic [28:0] pat   [NI];
  logic [6:0]  resp  [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic        pass  [NI];
  logic [15:0] sig   [NI];

  logic [28:0] nmask [7];
  logic [28:0] exp_pat [$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for the team's 29-in / 7-out combinational netlist
  function automatic logic [6:0] netlist(input logic [28:0] p);
    logic [6:0] o;
    for (int k = 0; k < 7; k++) o[k] = (^(p & nmask[k])) ^ (p[k] & p[k+11]);
    return o;
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++) resp[i] = (i == 2) ? 7'h55 : netlist(pat[i]);
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bist_pattern_driver #(
      .PAT_CNT   (PCNT[g]),
      .LFSR_SEED (SEEDS[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[g]),
      .golden_sig (gold[g]),
      .pat_o      (pat[g]),
      .resp_i     (resp[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .signature  (sig[g])
`ifdef BIST_ABORT_EN
      ,
      .abort      (abort[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: signature after n captures; fills exp_pat with p_0..p_n
  function automatic logic [15:0] ref_sig(input int i, input int n);
    logic [28:0] p;
    logic [15:0] m;
    logic [6:0]  r;
    int          fb;
    p = (SEEDS[i] == 29'h0) ? 29'h1fff_ffff : SEEDS[i];
    m = 16'h0;
    exp_pat.delete();
    for (int k = 0; k < n; k++) begin
      exp_pat.push_back(p);
      r  = (i == 2) ? 7'h55 : netlist(p);
      fb = $countones(m & 16'h8810) % 2;
      m  = {m[14:0], fb[0]} ^ {9'd0, r};
      p  = {p[27:0], p[28] ^ p[26]};
    end
    exp_pat.push_back(p);
    return m;
  endfunction

  task automatic do_run(input int i, input bit use_ref, input bit spam);
    logic [15:0] esig;
    logic [15:0] g;
    int          n;
    n    = PCNT[i];
    esig = ref_sig(i, n);
    g    = use_ref ? esig : 16'($urandom_range(0, 65535));
    gold[i]  = g;
    start[i] = 1'b1;
    tick;
    start[i] = 1'b0;
    chk($sformatf("seed_busy%0d", i), busy[i], 1);
    chk($sformatf("seed_done%0d", i), done[i], 0);
    for (int k = 0; k < n; k++) begin
      tick;
      start[i] = spam && (k % 2 == 0);
      if (k < 8) begin
        chk($sformatf("pat%0d_%0d", i, k), pat[i], exp_pat[k]);
        chk($sformatf("run_busy%0d", i), busy[i], 1);
      end
      if (k == n - 1) chk($sformatf("not_done_early%0d", i), done[i], 0);
    end
    tick;
    start[i] = 1'b0;
    chk($sformatf("done%0d", i), done[i], 1);
    chk($sformatf("done_busy%0d", i), busy[i], 0);
    chk($sformatf("sig%0d", i), sig[i], esig);
    chk($sformatf("pass%0d", i), pass[i], (esig == g));
    chk($sformatf("hold_pat%0d", i), pat[i], exp_pat[n]);
    tick;
    chk($sformatf("done_hold%0d", i), done[i], 1);
  endtask

`ifdef BIST_ABORT_EN
  task automatic do_abort(input int i, input int k_ab);
    logic [15:0] partial;
    partial  = ref_sig(i, k_ab);
    gold[i]  = partial;
    start[i] = 1'b1;
    tick;
    start[i] = 1'b0;
    for (int k = 0; k <= k_ab; k++) tick;
    abort[i] = 1'b1;
    tick;
    abort[i] = 1'b0;
    chk("abort_busy", busy[i], 0);
    chk("abort_done", done[i], 0);
    chk("abort_pass", pass[i], 0);
    chk("abort_sig", sig[i], partial);
    tick;
    chk("abort_idle_done", done[i], 0);
    chk("abort_idle_busy", busy[i], 0);
  endtask
`endif

  initial begin
    logic [15:0] s0;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      gold[i]  = 16'h0;
    end
    for (int k = 0; k < 7; k++) nmask[k] = 29'($urandom);
    tick;
    tick;
    for (int i = 0; i < NI; i++) begin
      chk("rst_pat", pat[i], 0);
      chk("rst_sig", sig[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_pass", pass[i], 0);
    end
    rst_n = 1'b1;
    tick;

    // single pattern on a constant response
    do_run(2, 1'b1, 1'b0);
    chk("len1_sig_const", sig[2], 16'h0055);
    gold[2] = 16'h0054;
    start[2] = 1'b1;
    tick;
    start[2] = 1'b0;
    tick;
    tick;
    chk("len1_done", done[2], 1);
    chk("len1_fail_pass", pass[2], 0);

    // zero patterns, zero seed replaced by all-ones
    gold[1] = 16'h0;
    do_run(1, 1'b1, 1'b0);
    chk("zero_seed_ones", pat[1], 29'h1fff_ffff);
    chk("zero_pass_gold0", pass[1], 1);
    do_run(1, 1'b0, 1'b0);

    // LFSR sequence from seed 1 and wrap of the top bit
    do_run(0, 1'b1, 1'b0);
    do_run(4, 1'b0, 1'b0);
    chk("wrap_next", exp_pat[1], 29'h0000_0001);

    // start pulses while busy must not restart or stretch the run
    do_run(0, 1'b1, 1'b1);

    // randomized netlists
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 7; k++) nmask[k] = 29'($urandom);
      do_run(0, ($urandom_range(0, 1) == 1), 1'b0);
      do_run(4, 1'b1, 1'b0);
    end

    // reset in the middle of a run
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    rst_n = 1'b0;
    tick;
    chk("mid_rst_pat", pat[0], 0);
    chk("mid_rst_sig", sig[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_done", done[0], 0);
    chk("mid_rst_pass", pass[0], 0);
    rst_n = 1'b1;
    tick;
    do_run(0, 1'b1, 1'b0);

    // full-length loopback, twice back to back
    do_run(3, 1'b1, 1'b0);
    s0 = ref_sig(3, PCNT[3]);
    do_run(3, 1'b1, 1'b0);
    chk("loop_repeat", sig[3], s0);

`ifdef BIST_ABORT_EN
    do_abort(0, 3);
    do_abort(0, PCNT[0] - 1);
    do_run(0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
